// File: rtl/spi_tx_arbiter.sv
// Two-requester AXI-Stream arbiter feeding one SPI transmit engine.
// Packet-atomic round-robin grants with a programmable idle gap between packets.
module spi_tx_arbiter #(
    parameter int unsigned C_AXIS_TDATA_WIDTH = 32,
    parameter int unsigned GAP_CYCLES         = 4,
    parameter int unsigned MAX_BEATS          = 0
) (
    input  logic                          ACLK,
    input  logic                          ARESET,
    input  logic [C_AXIS_TDATA_WIDTH-1:0] S0_AXIS_TDATA,
    input  logic                          S0_AXIS_TVALID,
    input  logic                          S0_AXIS_TLAST,
    output logic                          S0_AXIS_TREADY,
    input  logic [C_AXIS_TDATA_WIDTH-1:0] S1_AXIS_TDATA,
    input  logic                          S1_AXIS_TVALID,
    input  logic                          S1_AXIS_TLAST,
    output logic                          S1_AXIS_TREADY,
    output logic [C_AXIS_TDATA_WIDTH-1:0] M_AXIS_TDATA,
    output logic                          M_AXIS_TVALID,
    output logic                          M_AXIS_TLAST,
    input  logic                          M_AXIS_TREADY,
    output logic [1:0]                    grant,
    output logic                          busy
);

    localparam int unsigned BEAT_CNT_W = 16;
    localparam int unsigned GAP_CNT_W  = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT0 = 2'd1,
        ST_GRANT1 = 2'd2,
        ST_GAP    = 2'd3
    } state_t;

    state_t                        r_state;
    state_t                        w_state_nxt;
    logic                          r_last;
    logic                          w_last_nxt;
    logic [BEAT_CNT_W-1:0]         r_beat_cnt;
    logic [BEAT_CNT_W-1:0]         w_beat_cnt_nxt;
    logic [GAP_CNT_W-1:0]          r_gap_cnt;
    logic [GAP_CNT_W-1:0]          w_gap_cnt_nxt;
    logic                          r_m_valid;
    logic                          r_m_last;
    logic [C_AXIS_TDATA_WIDTH-1:0] r_m_data;

    logic                          w_out_free;
    logic                          w_max_hit;
    logic                          w_gap_done;
    logic                          w_s0_ready;
    logic                          w_s1_ready;
    logic                          w_accept;
    logic                          w_end_beat;
    logic                          w_src_last;
    logic [C_AXIS_TDATA_WIDTH-1:0] w_src_data;

    // Output register can take a beat when empty or draining this cycle.
    assign w_out_free = !r_m_valid || M_AXIS_TREADY;
    assign w_max_hit  = (MAX_BEATS != 0) && (r_beat_cnt == BEAT_CNT_W'(MAX_BEATS - 1));
    assign w_gap_done = (GAP_CYCLES == 0) || (r_gap_cnt == GAP_CNT_W'(GAP_CYCLES - 1));

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state    <= ST_IDLE;
            r_last     <= 1'b1;
            r_beat_cnt <= '0;
            r_gap_cnt  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_last     <= w_last_nxt;
            r_beat_cnt <= w_beat_cnt_nxt;
            r_gap_cnt  <= w_gap_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_last_nxt     = r_last;
        w_beat_cnt_nxt = r_beat_cnt;
        w_gap_cnt_nxt  = r_gap_cnt;
        w_s0_ready     = 1'b0;
        w_s1_ready     = 1'b0;
        w_accept       = 1'b0;
        w_end_beat     = 1'b0;
        w_src_data     = S0_AXIS_TDATA;
        w_src_last     = S0_AXIS_TLAST;

        case (r_state)
            ST_IDLE: begin
                w_beat_cnt_nxt = '0;
                w_gap_cnt_nxt  = '0;
                // On a tie the source that did not own the last grant wins.
                if (S0_AXIS_TVALID && (!S1_AXIS_TVALID || r_last)) begin
                    w_state_nxt = ST_GRANT0;
                    w_last_nxt  = 1'b0;
                end else if (S1_AXIS_TVALID) begin
                    w_state_nxt = ST_GRANT1;
                    w_last_nxt  = 1'b1;
                end
            end
            ST_GRANT0: begin
                w_s0_ready = w_out_free;
                w_accept   = S0_AXIS_TVALID && w_out_free;
            end
            ST_GRANT1: begin
                w_s1_ready = w_out_free;
                w_accept   = S1_AXIS_TVALID && w_out_free;
                w_src_data = S1_AXIS_TDATA;
                w_src_last = S1_AXIS_TLAST;
            end
            ST_GAP: begin
                // Gap counting waits until the final beat has left the output register.
                if (!r_m_valid) begin
                    if (w_gap_done) begin
                        w_state_nxt   = ST_IDLE;
                        w_gap_cnt_nxt = '0;
                    end else begin
                        w_gap_cnt_nxt = r_gap_cnt + GAP_CNT_W'(1);
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        w_end_beat = w_src_last || w_max_hit;
        if (w_accept) begin
            if (w_end_beat) begin
                w_state_nxt    = ST_GAP;
                w_beat_cnt_nxt = '0;
            end else begin
                w_beat_cnt_nxt = r_beat_cnt + BEAT_CNT_W'(1);
            end
        end
    end

    // Single output stage; a simultaneous load and drain keeps it valid.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_m_valid <= 1'b0;
            r_m_last  <= 1'b0;
            r_m_data  <= '0;
        end else if (w_accept) begin
            r_m_valid <= 1'b1;
            r_m_last  <= w_end_beat;
            r_m_data  <= w_src_data;
        end else if (M_AXIS_TREADY) begin
            r_m_valid <= 1'b0;
        end
    end

    assign S0_AXIS_TREADY = w_s0_ready;
    assign S1_AXIS_TREADY = w_s1_ready;
    assign M_AXIS_TDATA   = r_m_data;
    assign M_AXIS_TVALID  = r_m_valid;
    assign M_AXIS_TLAST   = r_m_last;
    assign grant          = {r_state == ST_GRANT1, r_state == ST_GRANT0};
    assign busy           = (r_state != ST_IDLE) || r_m_valid;

endmodule

// File: tb/tb_spi_tx_arbiter.sv
// Bench for spi_tx_arbiter: two instances (unlimited and MAX_BEATS=2) driven by
// directed and random AXIS traffic and compared against a transaction-level model.
module tb_spi_tx_arbiter;

    localparam int unsigned DW  = 32;
    localparam int unsigned GAP = 4;

    logic clk;
    int   n_cmp = 0;
    int   n_bad = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    genvar g;
    for (g = 0; g < 2; g++) begin : g_cfg
        localparam int unsigned MAXB = (g == 0) ? 0 : 2;

        logic          rst;
        logic [DW-1:0] s0_data, s1_data, m_data;
        logic          s0_valid, s0_last, s0_ready;
        logic          s1_valid, s1_last, s1_ready;
        logic          m_valid, m_last, m_ready, busy;
        logic [1:0]    grant;

        spi_tx_arbiter #(
            .C_AXIS_TDATA_WIDTH(DW),
            .GAP_CYCLES        (GAP),
            .MAX_BEATS         (MAXB)
        ) u_dut (
            .ACLK          (clk),
            .ARESET        (rst),
            .S0_AXIS_TDATA (s0_data),
            .S0_AXIS_TVALID(s0_valid),
            .S0_AXIS_TLAST (s0_last),
            .S0_AXIS_TREADY(s0_ready),
            .S1_AXIS_TDATA (s1_data),
            .S1_AXIS_TVALID(s1_valid),
            .S1_AXIS_TLAST (s1_last),
            .S1_AXIS_TREADY(s1_ready),
            .M_AXIS_TDATA  (m_data),
            .M_AXIS_TVALID (m_valid),
            .M_AXIS_TLAST  (m_last),
            .M_AXIS_TREADY (m_ready),
            .grant         (grant),
            .busy          (busy)
        );

        // Source packet queues: {tlast, tdata}
        logic [DW:0]   q0[$];
        logic [DW:0]   q1[$];
        bit            v0, v1, hs0, hs1, rst_req, done;
        int            pv, rmode, cyc, n_acc, tot;
        // Model: current owner (-1 none), last winner, beats in this grant,
        // first cycle arbitration may happen, output register contents.
        int            owner, last_own, gbeats, idle_from;
        bit            gap_wait, of, ol;
        logic [DW-1:0] od;
        logic [DW-1:0] out_d[$];
        bit            out_l[$];
        int            out_c[$];

        function automatic string t(input string s);
            return $sformatf("c%0d.%s", g, s);
        endfunction

        task automatic model_reset();
            owner = -1; last_own = 1; gbeats = 0; idle_from = 0;
            gap_wait = 0; of = 0; ol = 0; od = '0;
        endtask

        task automatic clear_log();
            out_d.delete(); out_l.delete(); out_c.delete();
        endtask

        task automatic push_pkt(input int src, input int len, input logic [DW-1:0] base);
            for (int i = 0; i < len; i++) begin
                if (src == 0) q0.push_back({1'(i == len - 1), base + DW'(i)});
                else          q1.push_back({1'(i == len - 1), base + DW'(i)});
            end
        endtask

        task automatic step();
            logic [1:0] eg;
            bit er0, er1, a0, a1, fl;
            int pick;
            @(posedge clk); #1;
            cyc++;
            if (hs0) begin if (q0.size() > 0) void'(q0.pop_front()); v0 = 0; end
            if (hs1) begin if (q1.size() > 0) void'(q1.pop_front()); v1 = 0; end
            if (!v0 && q0.size() > 0 && int'($urandom_range(99)) < pv) v0 = 1;
            if (!v1 && q1.size() > 0 && int'($urandom_range(99)) < pv) v1 = 1;
            s0_valid = v0;
            s0_data  = v0 ? q0[0][DW-1:0] : DW'($urandom());
            s0_last  = v0 ? q0[0][DW] : 1'($urandom_range(1));
            s1_valid = v1;
            s1_data  = v1 ? q1[0][DW-1:0] : DW'($urandom());
            s1_last  = v1 ? q1[0][DW] : 1'($urandom_range(1));
            if (rmode == 0)      m_ready = 1'b1;
            else if (rmode == 1) m_ready = 1'((cyc % 2) == 0);
            else                 m_ready = 1'($urandom_range(99) < 70);
            rst = rst_req;
            @(negedge clk);

            eg  = (owner == 0) ? 2'b01 : (owner == 1) ? 2'b10 : 2'b00;
            er0 = (owner == 0) && (!of || m_ready);
            er1 = (owner == 1) && (!of || m_ready);
            chk(t("grant"), 64'(grant), 64'(eg));
            chk(t("s0_ready"), 64'(s0_ready), 64'(er0));
            chk(t("s1_ready"), 64'(s1_ready), 64'(er1));
            chk(t("m_valid"), 64'(m_valid), 64'(of));
            chk(t("busy"), 64'(busy), 64'(owner >= 0 || gap_wait || cyc < idle_from || of));
            if (of) begin
                chk(t("m_data"), 64'(m_data), 64'(od));
                chk(t("m_last"), 64'(m_last), 64'(ol));
            end
            if (m_valid && m_ready) begin
                out_d.push_back(m_data); out_l.push_back(m_last); out_c.push_back(cyc);
            end
            hs0 = s0_valid && s0_ready;
            hs1 = s1_valid && s1_ready;

            a0 = s0_valid && er0;
            a1 = s1_valid && er1;
            if (rst) begin
                model_reset();
            end else begin
                if (a0 || a1) begin
                    n_acc++;
                    fl = (a0 ? s0_last : s1_last) || (MAXB != 0 && gbeats + 1 == int'(MAXB));
                    od = a0 ? s0_data : s1_data;
                    ol = fl;
                    of = 1;
                    if (fl) begin owner = -1; gap_wait = 1; gbeats = 0; end
                    else gbeats++;
                end else if (of && m_ready) begin
                    of = 0;
                    if (gap_wait) begin
                        gap_wait  = 0;
                        idle_from = cyc + ((GAP == 0) ? 1 : int'(GAP)) + 1;
                    end
                end
                if (owner < 0 && !gap_wait && cyc >= idle_from && (s0_valid || s1_valid)) begin
                    pick     = (s0_valid && (!s1_valid || last_own == 1)) ? 0 : 1;
                    owner    = pick;
                    last_own = pick;
                    gbeats   = 0;
                end
            end
        endtask

        task automatic run(input int n);
            repeat (n) step();
        endtask

        initial begin
            int lc;
            done = 0; cyc = 0; n_acc = 0; tot = 0;
            v0 = 0; v1 = 0; hs0 = 0; hs1 = 0;
            pv = 100; rmode = 0;
            rst = 1'b1; rst_req = 1;
            s0_valid = 0; s0_data = '0; s0_last = 0;
            s1_valid = 0; s1_data = '0; s1_last = 0;
            m_ready = 1'b1;
            model_reset();

            run(3);
            rst_req = 0;
            step();
            chk(t("rst.m_data"), 64'(m_data), 64'h0);
            chk(t("rst.m_last"), 64'(m_last), 64'h0);

            // Single 3-beat packet from S0
            clear_log();
            push_pkt(0, 3, 32'h0);
            q0.delete();
            q0.push_back({1'b0, 32'h0000AAAA});
            q0.push_back({1'b0, 32'h00005555});
            q0.push_back({1'b1, 32'h000000FF});
            run(20);
            chk(t("sgl.count"), 64'(out_d.size()), 64'd3);
            chk(t("sgl.d0"), 64'(out_d[0]), 64'h0000AAAA);
            chk(t("sgl.d1"), 64'(out_d[1]), 64'h00005555);
            chk(t("sgl.d2"), 64'(out_d[2]), 64'h000000FF);
            chk(t("sgl.last2"), 64'(out_l[2]), 64'd1);
            chk(t("sgl.span"), 64'(out_c[2] - out_c[0]), 64'((MAXB == 0) ? 2 : 8));

            // Tie right after reset: S0 first, S1 at least 6 cycles later
            rst_req = 1; step(); rst_req = 0;
            clear_log();
            push_pkt(0, 1, 32'h11);
            push_pkt(1, 1, 32'h22);
            run(25);
            chk(t("tie.first"), 64'(out_d[0]), 64'h11);
            chk(t("tie.second"), 64'(out_d[1]), 64'h22);
            chk(t("tie.space"), 64'(out_c[1] - out_c[0] >= 6), 64'd1);

            // Fairness: S1 is served between S0 packets
            clear_log();
            for (int i = 0; i < 3; i++) push_pkt(0, 1, 32'hA0 + DW'(i));
            push_pkt(1, 1, 32'hB0);
            run(45);
            chk(t("fair.0"), 64'(out_d[0]), 64'hA0);
            chk(t("fair.1"), 64'(out_d[1]), 64'hB0);
            chk(t("fair.2"), 64'(out_d[2]), 64'hA1);

            // Backpressure: M ready toggling during a 4-beat S1 packet
            clear_log();
            rmode = 1;
            push_pkt(1, 4, 32'hC0);
            run(35);
            rmode = 0;
            chk(t("bp.count"), 64'(out_d.size()), 64'd4);
            for (int i = 0; i < 4; i++) chk(t("bp.data"), 64'(out_d[i]), 64'(32'hC0 + i));

            // 5-beat packet: split into grants of MAXB beats when limited
            clear_log();
            push_pkt(0, 5, 32'hD0);
            run(60);
            chk(t("max.count"), 64'(out_d.size()), 64'd5);
            for (int i = 0; i < 5; i++) begin
                chk(t("max.data"), 64'(out_d[i]), 64'(32'hD0 + i));
                chk(t("max.last"), 64'(out_l[i]), 64'(i == 4 || (MAXB != 0 && (i + 1) % MAXB == 0)));
            end

            // Reset while beat 2 of 4 is being accepted
            clear_log();
            n_acc = 0;
            push_pkt(0, 4, 32'hE0);
            lc = 0;
            while (n_acc < 1 && lc < 30) begin step(); lc++; end
            chk(t("rstmid.started"), 64'(n_acc), 64'd1);
            rst_req = 1; step(); rst_req = 0;
            q0.delete(); q1.delete(); v0 = 0; v1 = 0; hs0 = 0; hs1 = 0;
            step();
            chk(t("rstmid.grant"), 64'(grant), 64'h0);
            chk(t("rstmid.m_valid"), 64'(m_valid), 64'h0);
            chk(t("rstmid.m_last"), 64'(m_last), 64'h0);
            chk(t("rstmid.m_data"), 64'(m_data), 64'h0);
            clear_log();
            push_pkt(1, 2, 32'hF0);
            run(25);
            chk(t("rstmid.count"), 64'(out_d.size()), 64'd2);
            chk(t("rstmid.d0"), 64'(out_d[0]), 64'hF0);
            chk(t("rstmid.d1"), 64'(out_d[1]), 64'hF1);

            // Random traffic from both sources with random backpressure
            clear_log();
            rmode = 2;
            tot = 0;
            for (int c = 0; c < 3000; c++) begin
                int len;
                if (c % 200 == 0) pv = int'($urandom_range(100, 40));
                if (q0.size() < 4 && $urandom_range(7) == 0) begin
                    len = int'($urandom_range(6, 1));
                    push_pkt(0, len, DW'($urandom())); tot += len;
                end
                if (q1.size() < 4 && $urandom_range(7) == 0) begin
                    len = int'($urandom_range(6, 1));
                    push_pkt(1, len, DW'($urandom())); tot += len;
                end
                step();
            end
            rmode = 0; pv = 100;
            run(150);
            chk(t("rnd.q0_empty"), 64'(q0.size()), 64'd0);
            chk(t("rnd.q1_empty"), 64'(q1.size()), 64'd0);
            chk(t("rnd.count"), 64'(out_d.size()), 64'(tot));
            chk(t("rnd.idle_busy"), 64'(busy), 64'd0);
            done = 1;
        end
    end

    initial begin
        for (int i = 0; i < 90000; i++) begin
            if (g_cfg[0].done && g_cfg[1].done) break;
            @(posedge clk);
        end
        chk("done", 64'({g_cfg[0].done, g_cfg[1].done}), 64'b11);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
